// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// cnt_width sizes a counter that must be able to hold the value max.
package dmem_arb_pkg;

  localparam int AW_DEF       = 32;
  localparam int DW_DEF       = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam int LOCK_MAX_DEF = 8;

  typedef enum logic {ARB, LOCKED} arb_state_t;
  typedef enum logic {OWN_C, OWN_D} owner_t;

  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          stall_core;

  logic          d_req;
  logic          d_we;
  logic          d_lock;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_lock, d_addr, d_wdata,
    input  m_rdata,
    output c_gnt, c_rvalid, c_rdata, stall_core,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_lock, d_addr, d_wdata,
    output m_rdata,
    input  c_gnt, c_rvalid, c_rdata, stall_core,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter. clr together with inc restarts the count at 1;
// hit_max flags that the value being loaded this cycle equals MAX.
module arb_sat_counter #(
  parameter int W   = 3,
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic at_max,
  output logic hit_max
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = inc ? W'(1) : '0;
    else if (inc && !at_max)
      cnt_d = cnt_q + W'(1);
  end

  assign at_max  = (cnt_q == W'(MAX));
  assign hit_max = inc && (cnt_d == W'(MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core (C) and debug (D) share one synchronous-read port.
// Grants are combinational; read data returns to its owner one cycle later.
//
// state  | meaning
// ARB    | core has priority; D wins when alone or after MAX_WAIT denials
// LOCKED | debug owns the memory; core stalled until d_lock drops or LOCK_MAX grants
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  dmem_arbiter_if.slave bus
);
  localparam int WAIT_W = cnt_width(MAX_WAIT);
  localparam int LOCK_W = cnt_width(LOCK_MAX);

  arb_state_t    state_q, state_d;
  owner_t        rd_owner_q, rd_owner_d;
  logic          core_prio_q, core_prio_d;
  logic          rd_pend_q, rd_pend_d;
  logic          c_gnt, d_gnt, lock_hold;
  logic          wait_at_max, lock_hit;
  logic          wait_hit_unused, lock_at_max_unused;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  assign lock_hold = (state_q == LOCKED) && bus.d_lock;

  arb_sat_counter #(.W(WAIT_W), .MAX(MAX_WAIT)) u_wait_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (d_gnt || !bus.d_req),
    .inc     (bus.d_req && !d_gnt),
    .at_max  (wait_at_max),
    .hit_max (wait_hit_unused)
  );

  // Lock count only survives while the lock is held; an ARB-state grant with d_lock restarts it at 1.
  arb_sat_counter #(.W(LOCK_W), .MAX(LOCK_MAX)) u_lock_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!lock_hold),
    .inc     (d_gnt && bus.d_lock),
    .at_max  (lock_at_max_unused),
    .hit_max (lock_hit)
  );

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset_n) begin
      if (lock_hold) begin
        d_gnt = bus.d_req;
      end else begin
        c_gnt = bus.c_req && (core_prio_q || !(bus.d_req && wait_at_max));
        d_gnt = bus.d_req && !c_gnt;
      end
    end

    bus.m_we = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    if (c_gnt) begin
      bus.m_we = bus.c_we;
      m_addr   = bus.c_addr;
      m_wdata  = bus.c_wdata;
    end else if (d_gnt) begin
      bus.m_we = bus.d_we;
      m_addr   = bus.d_addr;
      m_wdata  = bus.d_wdata;
    end
    bus.m_en    = c_gnt || d_gnt;
    bus.m_addr  = m_addr;
    bus.m_wdata = m_wdata;

    bus.c_gnt      = c_gnt;
    bus.d_gnt      = d_gnt;
    bus.stall_core = reset_n && bus.c_req && !c_gnt;
    bus.c_rvalid   = rd_pend_q && (rd_owner_q == OWN_C);
    bus.d_rvalid   = rd_pend_q && (rd_owner_q == OWN_D);
    bus.c_rdata    = bus.c_rvalid ? bus.m_rdata : '0;
    bus.d_rdata    = bus.d_rvalid ? bus.m_rdata : '0;
  end

  always_comb begin
    state_d     = state_q;
    core_prio_d = 1'b0;
    if (d_gnt && bus.d_lock) begin
      state_d     = lock_hit ? ARB : LOCKED;
      core_prio_d = lock_hit;
    end else if (!lock_hold) begin
      state_d = ARB;
    end
    rd_pend_d  = (c_gnt && !bus.c_we) || (d_gnt && !bus.d_we);
    rd_owner_d = d_gnt ? OWN_D : OWN_C;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB;
      core_prio_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= OWN_C;
    end else begin
      state_q     <= state_d;
      core_prio_q <= core_prio_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural sync-read memory and a
// response scoreboard (one expected response entry per cycle).
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus();

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .LOCK_MAX(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0000_0011;
      1:       return 32'h0000_0022;
      4:       return 32'hDEAD_BEEF;
      default: return 32'hA500_0000 | 32'(i);
    endcase
  endfunction

  logic [31:0] mem [64];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr[7:2]] <= bus.m_wdata;
      else          bus.m_rdata <= mem[bus.m_addr[7:2]];
    end
  end

  typedef struct packed {
    logic        cv;
    logic        dv;
    logic [31:0] data;
  } resp_t;

  resp_t       rq[$];
  resp_t       none = '0;
  logic [31:0] exp_mem [64];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_c_gnt"},    bus.c_gnt,      1'b0);
    chk1({tag, "_d_gnt"},    bus.d_gnt,      1'b0);
    chk1({tag, "_c_rvalid"}, bus.c_rvalid,   1'b0);
    chk1({tag, "_d_rvalid"}, bus.d_rvalid,   1'b0);
    chk1({tag, "_stall"},    bus.stall_core, 1'b0);
    chk1({tag, "_m_en"},     bus.m_en,       1'b0);
    chk1({tag, "_m_we"},     bus.m_we,       1'b0);
    chk ({tag, "_c_rdata"},  bus.c_rdata,    32'h0);
    chk ({tag, "_d_rdata"},  bus.d_rdata,    32'h0);
    chk ({tag, "_m_addr"},   bus.m_addr,     32'h0);
    chk ({tag, "_m_wdata"},  bus.m_wdata,    32'h0);
  endtask

  // Called at posedge+1: drive, check at posedge+4, push expected response, advance.
  task automatic cyc(input string tag,
                     input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cwd,
                     input logic dr, input logic dw, input logic dl, input logic [31:0] da,
                     input logic [31:0] dwd, input logic ecg, input logic edg);
    resp_t       r;
    logic [31:0] ea, ewd;
    logic        ewe;
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cwd;
    bus.d_req = dr; bus.d_we = dw; bus.d_lock = dl; bus.d_addr = da; bus.d_wdata = dwd;
    #3;
    if (rq.size() == 0) begin
      chk({tag, "_resp_queue"}, 32'(rq.size()), 32'd1);
    end else begin
      r = rq.pop_front();
      chk1({tag, "_c_rvalid"}, bus.c_rvalid, r.cv);
      chk1({tag, "_d_rvalid"}, bus.d_rvalid, r.dv);
      if (r.cv) chk({tag, "_c_rdata"}, bus.c_rdata, r.data);
      if (r.dv) chk({tag, "_d_rdata"}, bus.d_rdata, r.data);
    end
    ea  = ecg ? ca  : (edg ? da  : 32'h0);
    ewd = ecg ? cwd : (edg ? dwd : 32'h0);
    ewe = ecg ? cw  : (edg ? dw  : 1'b0);
    chk1({tag, "_c_gnt"}, bus.c_gnt,      ecg);
    chk1({tag, "_d_gnt"}, bus.d_gnt,      edg);
    chk1({tag, "_stall"}, bus.stall_core, cr && !ecg);
    chk1({tag, "_m_en"},  bus.m_en,       ecg || edg);
    chk1({tag, "_m_we"},  bus.m_we,       ewe);
    chk ({tag, "_m_addr"}, bus.m_addr,    ea);
    if (ewe) chk({tag, "_m_wdata"}, bus.m_wdata, ewd);
    r = '0;
    if (ecg && !cw) begin
      r.cv = 1'b1; r.data = exp_mem[ca[7:2]];
    end else if (edg && !dw) begin
      r.dv = 1'b1; r.data = exp_mem[da[7:2]];
    end
    if (ecg && cw) exp_mem[ca[7:2]] = cwd;
    if (edg && dw) exp_mem[da[7:2]] = dwd;
    rq.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input string tag);
    cyc(tag, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  initial begin
    logic [0:17] t3_d;
    reset_n = 1'b0;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_lock = 0; bus.d_addr = '0; bus.d_wdata = '0;
    for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1;
    // Requests during reset must not leak to any output.
    bus.c_req = 1; bus.d_req = 1; bus.d_lock = 1; bus.c_addr = 32'h10;
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rq.push_back(none);

    // 1: core read alone
    cyc("t1_rd", 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    idle_cyc("t1_rsp");

    // 2: continuous contention, D force-granted every fifth cycle
    for (int k = 0; k < 10; k++)
      cyc("t2", 1, 0, 32'h0, 32'h0, 1, 0, 0, 32'h4, 32'h0, (k % 5) != 4, (k % 5) == 4);
    idle_cyc("t2_end");

    // 4: alternating owners, back-to-back reads
    cyc("t4_c0", 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h4, 32'h0, 1, 0);
    cyc("t4_d0", 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h4, 32'h0, 0, 1);
    cyc("t4_c1", 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h4, 32'h0, 1, 0);
    cyc("t4_d1", 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h4, 32'h0, 0, 1);
    idle_cyc("t4_end");

    // 5: debug write then core read of the same word
    cyc("t5_dwr", 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h20, 32'hCAFE_F00D, 0, 1);
    cyc("t5_crd", 1, 0, 32'h20, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    idle_cyc("t5_rsp");
    chk("t5_mem", exp_mem[8], 32'hCAFE_F00D);

    // 3: lock contention. Core wins 4 (lock ignored), D holds 8, core once,
    // D starves to MAX_WAIT again and re-locks; dropping d_lock returns to ARB.
    t3_d = 18'b0000_1111_1111_0000_11;
    for (int k = 0; k < 18; k++)
      cyc("t3", 1, 0, 32'h0, 32'h0, 1, 0, 1, 32'h4, 32'h0, !t3_d[k], t3_d[k]);
    cyc("t3_unlock", 1, 0, 32'h0, 32'h0, 1, 0, 0, 32'h4, 32'h0, 1, 0);
    idle_cyc("t3_end");

    // 6: reset the cycle after a read grant
    cyc("t6_rd", 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    reset_n = 1'b0;
    #3;
    chk_all_zero("t6_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rq.delete();
    rq.push_back(none);
    cyc("t6_rel", 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
    idle_cyc("t6_rsp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
